// File: rtl/aud_pwm_capture.sv
// rtl/aud_pwm_capture.sv - PWM audio duty-cycle capture, one sample per 2^DATA_WIDTH-tick window.
// Optional majority glitch filter on the synchronized input: AUD_CAP_GLITCH_FILTER_EN.
module aud_pwm_capture #(
    parameter int DATA_WIDTH  = 8,
    parameter int CLK_DIV     = 1,
    parameter int CAPTURE_LEN = 190000,
    parameter int IDX_WIDTH   = 24
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  pwm_in,
    input  logic                  start,
    input  logic                  stop,
    output logic [DATA_WIDTH-1:0] sample_data,
    output logic [IDX_WIDTH-1:0]  sample_index,
    output logic                  sample_valid,
    input  logic                  sample_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic [1:0]            state;
    logic                  pwm_m;
    logic                  pwm_s;
    logic                  pwm_bit;
    logic [DIV_W-1:0]      div_cnt;
    logic [DATA_WIDTH-1:0] win_cnt;
    logic [DATA_WIDTH:0]   hi_cnt;
    logic [DATA_WIDTH:0]   hi_next;
    logic [IDX_WIDTH-1:0]  run_cnt;
    logic [IDX_WIDTH-1:0]  run_next;
    logic [DATA_WIDTH-1:0] sample_next;
    logic                  in_cap;
    logic                  arm;
    logic                  tick;
    logic                  advance;
    logic                  win_close;
    logic                  run_last;

    assign in_cap    = (state == ST_CAPTURE);
    assign arm       = (state == ST_IDLE) && start;
    assign tick      = (div_cnt == DIV_W'(CLK_DIV - 1));
    // stop wins over a window close in the same cycle: the partial window is dropped.
    assign advance   = in_cap && tick && !stop;
    assign win_close = advance && (&win_cnt);
    assign hi_next   = hi_cnt + (DATA_WIDTH + 1)'(pwm_bit);
    assign run_next  = run_cnt + IDX_WIDTH'(1);
    assign run_last  = (run_next == IDX_WIDTH'(CAPTURE_LEN));

    assign busy = in_cap;
    assign done = (state == ST_DONE);

    // hi_next spans 0..2^DATA_WIDTH; a full-high window maps to all-ones.
    always_comb begin
        sample_next = '0;
        if (hi_next[DATA_WIDTH]) begin
            sample_next = '1;
        end else if (hi_next[DATA_WIDTH-1:0] != '0) begin
            sample_next = hi_next[DATA_WIDTH-1:0] - DATA_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pwm_m <= 1'b0;
            pwm_s <= 1'b0;
        end else begin
            pwm_m <= pwm_in;
            pwm_s <= pwm_m;
        end
    end

`ifdef AUD_CAP_GLITCH_FILTER_EN
    logic [2:0] filt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            filt <= '0;
        end else if (arm) begin
            filt <= '0;
        end else if (in_cap && tick) begin
            filt <= {filt[1:0], pwm_s};
        end
    end

    assign pwm_bit = (filt[0] & filt[1]) | (filt[1] & filt[2]) | (filt[0] & filt[2]);
`else
    assign pwm_bit = pwm_s;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (win_close && run_last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!start) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_cnt <= '0;
        end else if (arm) begin
            div_cnt <= '0;
        end else if (in_cap && !stop) begin
            if (tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            win_cnt <= '0;
            hi_cnt  <= '0;
            run_cnt <= '0;
        end else if (arm) begin
            win_cnt <= '0;
            hi_cnt  <= '0;
            run_cnt <= '0;
        end else if (advance) begin
            win_cnt <= win_cnt + DATA_WIDTH'(1);
            if (win_close) begin
                hi_cnt  <= '0;
                run_cnt <= run_next;
            end else begin
                hi_cnt <= hi_next;
            end
        end
    end

    // A load in the same cycle as a transfer keeps valid high with the new sample.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sample_data  <= '0;
            sample_index <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (win_close) begin
                sample_data  <= sample_next;
                sample_index <= run_cnt;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end

            if (arm) begin
                overrun <= 1'b0;
            end else if (win_close && sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aud_pwm_capture.sv
// tb/tb_aud_pwm_capture.sv - directed self-checking bench for aud_pwm_capture.
`timescale 1ns/1ps
module tb_aud_pwm_capture;

    logic        clk;
    logic        resetn;
    logic        pwm_in;
    logic        start;
    logic        stop;
    logic [7:0]  sample_data;
    logic [23:0] sample_index;
    logic        sample_valid;
    logic        sample_ready;
    logic        busy;
    logic        done;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int mode   = 0;
    int cyc    = 0;
    int n;

    aud_pwm_capture #(
        .DATA_WIDTH (8),
        .CLK_DIV    (1),
        .CAPTURE_LEN(4),
        .IDX_WIDTH  (24)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .pwm_in      (pwm_in),
        .start       (start),
        .stop        (stop),
        .sample_data (sample_data),
        .sample_index(sample_index),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Periodic PWM patterns: any 256-periodic pattern gives the same count per window.
    initial begin
        pwm_in = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            case (mode)
                1:       pwm_in = 1'b1;
                2:       pwm_in = ((cyc % 256) < 128);
                3:       pwm_in = ((cyc % 16) == 0);
                default: pwm_in = 1'b0;
            endcase
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int limit, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!sample_valid && cnt < limit);
        chk("valid_timeout", {31'd0, sample_valid}, 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
    endtask

    initial begin
        resetn       = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        sample_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",   {31'd0, sample_valid}, 32'd0);
        chk("rst_busy",    {31'd0, busy},         32'd0);
        chk("rst_done",    {31'd0, done},         32'd0);
        chk("rst_overrun", {31'd0, overrun},      32'd0);
        chk("rst_data",    {24'd0, sample_data},  32'd0);
        chk("rst_index",   {8'd0, sample_index},  32'd0);

        // Full-high input, start held for the whole run.
        resetn = 1'b1;
        mode   = 1;
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1;
        wait_valid(400, n);
        chk("hi_latency", n, 32'd257);
        chk("hi_busy",    {31'd0, busy},        32'd1);
        chk("hi_data0",   {24'd0, sample_data}, 32'd255);
        chk("hi_index0",  {8'd0, sample_index}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            wait_valid(300, n);
            chk("hi_data",  {24'd0, sample_data}, 32'd255);
            chk("hi_index", {8'd0, sample_index}, i);
        end
        chk("hi_done_last", {31'd0, done}, 32'd1);
        chk("hi_busy_last", {31'd0, busy}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("hi_done_held", {31'd0, done}, 32'd1);
        chk("hi_no_retrig", {31'd0, busy}, 32'd0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("hi_idle_done", {31'd0, done}, 32'd0);
        chk("hi_idle_busy", {31'd0, busy}, 32'd0);

        // All-low input, fresh run restarts at index 0.
        mode = 0;
        repeat (5) @(posedge clk);
        #1;
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            wait_valid(300, n);
            chk("lo_data",  {24'd0, sample_data}, 32'd0);
            chk("lo_index", {8'd0, sample_index}, i);
        end
        chk("lo_done", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        chk("lo_done_drop", {31'd0, done}, 32'd0);

        // Half duty, then abort with stop.
        mode = 2;
        repeat (5) @(posedge clk);
        #1;
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            wait_valid(300, n);
            chk("half_data",  {24'd0, sample_data}, 32'd127);
            chk("half_index", {8'd0, sample_index}, i);
        end
        repeat (20) @(posedge clk);
        #1;
        pulse_stop();
        chk("stop_busy", {31'd0, busy}, 32'd0);
        repeat (300) @(posedge clk);
        #1;
        chk("stop_no_sample", {31'd0, sample_valid}, 32'd0);

        // Overrun: second window sees two trailing highs from the synchronizer lag.
        mode         = 1;
        sample_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        pulse_start();
        wait_valid(300, n);
        mode = 0;
        chk("ovr_data0",   {24'd0, sample_data}, 32'd255);
        chk("ovr_clear0",  {31'd0, overrun},     32'd0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (sample_index != 24'd1 && n < 300);
        chk("ovr_index",  {8'd0, sample_index}, 32'd1);
        chk("ovr_data1",  {24'd0, sample_data}, 32'd1);
        chk("ovr_flag",   {31'd0, overrun},     32'd1);
        chk("ovr_valid",  {31'd0, sample_valid}, 32'd1);
        sample_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("ovr_xfer_valid", {31'd0, sample_valid}, 32'd0);
        chk("ovr_sticky",     {31'd0, overrun},      32'd1);
        pulse_stop();
        chk("ovr_idle_sticky", {31'd0, overrun}, 32'd1);
        pulse_start();
        chk("ovr_restart_clr",  {31'd0, overrun}, 32'd0);
        chk("ovr_restart_busy", {31'd0, busy},    32'd1);
        pulse_stop();

        // Isolated single-tick pulses every 16 ticks, then async reset mid window 3.
        mode = 3;
        repeat (5) @(posedge clk);
        #1;
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            wait_valid(300, n);
            chk("pulse_data",  {24'd0, sample_data}, 32'd15);
            chk("pulse_index", {8'd0, sample_index}, i);
        end
        repeat (100) @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        chk("arst_busy",    {31'd0, busy},         32'd0);
        chk("arst_index",   {8'd0, sample_index},  32'd0);
        chk("arst_data",    {24'd0, sample_data},  32'd0);
        chk("arst_valid",   {31'd0, sample_valid}, 32'd0);
        chk("arst_done",    {31'd0, done},         32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_valid", {31'd0, sample_valid}, 32'd0);
        chk("post_rst_busy",  {31'd0, busy},         32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
